clock_time_controller: RTL and testbench
========================================

CLOCK_TIME_CONTROLLER -- requirements
Module: clock_time_controller

Interface
REQ-001 SHALL have parameter HOLD_SCAN, default 5000: tick_scan pulses btn_inc must be held before auto-repeat starts.
REQ-002 SHALL have parameter REPEAT_SCAN, default 1000: tick_scan pulses between auto-repeat increments.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port tick_1hz  input  1  one-clk-wide enable pulse, 1 Hz.
REQ-006 SHALL have port tick_scan  input  1  one-clk-wide enable pulse, 10 kHz.
REQ-007 SHALL have port btn_mode  input  1  debounced, clk-synchronous level, high = pressed.
REQ-008 SHALL have port btn_inc  input  1  debounced, clk-synchronous level, high = pressed.
REQ-009 SHALL have port hr_bcd  output  8  hours, packed BCD {tens,ones}, 00-23.
REQ-010 SHALL have port min_bcd  output  8  minutes, packed BCD, 00-59.
REQ-011 SHALL have port sec_bcd  output  8  seconds, packed BCD, 00-59.
REQ-012 SHALL have port mode  output  2  state: 0 RUN, 1 SET_HR, 2 SET_MIN; 3 never driven.
REQ-013 SHALL have port blank_hr  output  1  high = display blanks hour digits (blink).
REQ-014 SHALL have port blank_min  output  1  high = display blanks minute digits (blink).

Function
REQ-015 SHALL register btn_mode and btn_inc once and act only on rising edges (current high, previous low); one edge = one action.
REQ-016 SHALL implement FSM RUN -> SET_HR -> SET_MIN -> RUN, advancing one state per btn_mode rising edge.
REQ-017 SHALL clear sec_bcd to 00 in the same cycle as the SET_MIN -> RUN transition.
REQ-018 SHALL, in RUN, on each tick_1hz, increment time: sec 59 -> 00 with carry to min; min 59 -> 00 with carry to hr; hr 23 -> 00; 23:59:59 -> 00:00:00 in one cycle.
REQ-019 SHALL update the outputs on the clk edge where tick_1hz is sampled high (latency one cycle from pulse to output).
REQ-020 SHALL perform all increments in BCD: ones 9 -> 0 with tens+1; outputs never hold non-BCD nibbles or out-of-range values.
REQ-021 SHALL ignore tick_1hz for timekeeping in SET_HR and SET_MIN; seconds freeze.
REQ-022 SHALL, in SET_HR, increment hr_bcd on each btn_inc rising edge, 23 -> 00, no effect on min or sec.
REQ-023 SHALL, in SET_MIN, increment min_bcd on each btn_inc rising edge, 59 -> 00, with no carry into hr.
REQ-024 SHALL ignore btn_inc in RUN.
REQ-025 SHALL count tick_scan pulses while btn_inc is held in a set state; after HOLD_SCAN pulses issue one increment, then one every REPEAT_SCAN pulses until release.
REQ-026 SHALL clear the hold counter on btn_inc low, on any state change, and on reset.
REQ-027 SHALL give btn_mode edge priority when it coincides with a btn_inc edge or auto-repeat increment: state advances, increment dropped.
REQ-028 SHALL apply a tick_1hz coinciding with a btn_mode edge in RUN: time advances and state moves to SET_HR in the same cycle.
REQ-029 SHALL keep blink_phase, toggled on each tick_1hz while in a set state and cleared on every state transition.
REQ-030 SHALL drive blank_hr = (SET_HR and blink_phase), blank_min = (SET_MIN and blink_phase), both registered; both low in RUN.
REQ-031 SHALL force blink_phase to 0 for the cycle of any increment in a set state, so the edited field is visible immediately.

Reset
REQ-032 SHALL, on rst high, asynchronously set hr_bcd, min_bcd, sec_bcd to 8'h00, mode to 0 (RUN), blank_hr and blank_min to 0, blink_phase, hold counter and button history to 0.
REQ-033 SHALL, on rst asserted mid-set or mid-hold, abandon the operation with no partial increment; first action after release needs a fresh rising edge.

Verification
REQ-034 SHALL verify rollover: preload 23:59:58 via set mode, RUN, two tick_1hz -> 23:59:59 then 00:00:00.
REQ-035 SHALL verify set flow: mode edge, 5 inc edges -> hr 05; mode edge, 60 inc edges -> min 00 with hr still 05; mode edge -> RUN, sec 00.
REQ-036 SHALL verify auto-repeat with HOLD_SCAN=4, REPEAT_SCAN=2: hold btn_inc in SET_MIN for 10 tick_scan -> min +1 (edge) +1 (hold) +3 (repeat) = 05.
REQ-037 SHALL verify priority: mode and inc edges same cycle in SET_HR -> state SET_MIN, hr unchanged.
REQ-038 SHALL verify blink: in SET_HR, tick_1hz pulses -> blank_hr 1,0,1; blank_min stays 0; inc edge -> blank_hr 0 that cycle.
REQ-039 SHALL verify reset: assert rst in SET_MIN at 12:34 mid-hold -> next cycle 00:00:00, mode 0, blanks 0.

Source files
------------

// File: rtl/clock_time_controller.sv
// HH:MM:SS BCD timekeeper with RUN/SET_HR/SET_MIN editing, hold-to-repeat increment and field blink.
// Outputs update one clk after the sampled tick or button edge; buttons are level inputs, no backpressure.
module clock_time_controller #(
   parameter int HOLD_SCAN   = 5000,
   parameter int REPEAT_SCAN = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       tick_scan,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic [7:0] hr_bcd,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic [1:0] mode,
   output logic       blank_hr,
   output logic       blank_min
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SET_HR  = 2'd1,
      SET_MIN = 2'd2
   } state_t;

   localparam int CNT_MAX = (HOLD_SCAN > REPEAT_SCAN) ? HOLD_SCAN : REPEAT_SCAN;
   localparam int CW      = $clog2(CNT_MAX + 1);

   state_t        state_q, state_d;
   logic          btn_mode_q, btn_inc_q, armed_q;
   logic [CW-1:0] hold_cnt_q, hold_cnt_d;
   logic          repeating_q, repeating_d;
   logic          blink_q, blink_d;
   logic [7:0]    hr_q, min_q, sec_q, hr_d, min_d, sec_d;
   logic          blank_hr_q, blank_min_q;
   logic          mode_edge, inc_edge, in_set, rpt_fire, bump;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
      if (v == top)
         return 8'h00;
      if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   // armed_q masks the first cycle after reset so a button held through reset is not taken as an edge
   always_comb begin
      mode_edge = armed_q & btn_mode & ~btn_mode_q;
      inc_edge  = armed_q & btn_inc & ~btn_inc_q;
      in_set    = (state_q != RUN);
   end

   always_comb begin
      hold_cnt_d  = hold_cnt_q;
      repeating_d = repeating_q;
      rpt_fire    = 1'b0;
      if (!btn_inc || !in_set || mode_edge) begin
         hold_cnt_d  = '0;
         repeating_d = 1'b0;
      end else if (tick_scan) begin
         if (!repeating_q) begin
            if (hold_cnt_q == CW'(HOLD_SCAN - 1)) begin
               rpt_fire    = 1'b1;
               hold_cnt_d  = '0;
               repeating_d = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q + CW'(1);
            end
         end else if (hold_cnt_q == CW'(REPEAT_SCAN - 1)) begin
            rpt_fire   = 1'b1;
            hold_cnt_d = '0;
         end else begin
            hold_cnt_d = hold_cnt_q + CW'(1);
         end
      end
   end

   // A mode edge wins over any increment landing in the same cycle
   assign bump = in_set & (inc_edge | rpt_fire) & ~mode_edge;

   always_comb begin
      state_d = state_q;
      hr_d    = hr_q;
      min_d   = min_q;
      sec_d   = sec_q;
      case (state_q)
         RUN: begin
            if (tick_1hz) begin
               sec_d = bcd_inc(sec_q, 8'h59);
               if (sec_q == 8'h59) begin
                  min_d = bcd_inc(min_q, 8'h59);
                  if (min_q == 8'h59)
                     hr_d = bcd_inc(hr_q, 8'h23);
               end
            end
            if (mode_edge)
               state_d = SET_HR;
         end
         SET_HR: begin
            if (mode_edge)
               state_d = SET_MIN;
            else if (bump)
               hr_d = bcd_inc(hr_q, 8'h23);
         end
         SET_MIN: begin
            if (mode_edge) begin
               state_d = RUN;
               sec_d   = 8'h00;
            end else if (bump) begin
               min_d = bcd_inc(min_q, 8'h59);
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      blink_d = blink_q;
      if (state_d != state_q || bump)
         blink_d = 1'b0;
      else if (in_set && tick_1hz)
         blink_d = ~blink_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         btn_mode_q  <= 1'b0;
         btn_inc_q   <= 1'b0;
         armed_q     <= 1'b0;
         hold_cnt_q  <= '0;
         repeating_q <= 1'b0;
         blink_q     <= 1'b0;
         hr_q        <= 8'h00;
         min_q       <= 8'h00;
         sec_q       <= 8'h00;
         blank_hr_q  <= 1'b0;
         blank_min_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         btn_mode_q  <= btn_mode;
         btn_inc_q   <= btn_inc;
         armed_q     <= 1'b1;
         hold_cnt_q  <= hold_cnt_d;
         repeating_q <= repeating_d;
         blink_q     <= blink_d;
         hr_q        <= hr_d;
         min_q       <= min_d;
         sec_q       <= sec_d;
         blank_hr_q  <= (state_d == SET_HR) & blink_d;
         blank_min_q <= (state_d == SET_MIN) & blink_d;
      end
   end

   assign hr_bcd    = hr_q;
   assign min_bcd   = min_q;
   assign sec_bcd   = sec_q;
   assign mode      = state_q;
   assign blank_hr  = blank_hr_q;
   assign blank_min = blank_min_q;

endmodule

// File: tb/tb_clock_time_controller.sv
// Directed bench for clock_time_controller: set flow, rollover, blink, priority, auto-repeat, reset.
module tb_clock_time_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick_1hz = 1'b0;
   logic       tick_scan = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic [7:0] hr_bcd, min_bcd, sec_bcd;
   logic [1:0] mode;
   logic       blank_hr, blank_min;

   int vectors = 0;
   int errors  = 0;

   clock_time_controller #(.HOLD_SCAN(4), .REPEAT_SCAN(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .tick_1hz  (tick_1hz),
      .tick_scan (tick_scan),
      .btn_mode  (btn_mode),
      .btn_inc   (btn_inc),
      .hr_bcd    (hr_bcd),
      .min_bcd   (min_bcd),
      .sec_bcd   (sec_bcd),
      .mode      (mode),
      .blank_hr  (blank_hr),
      .blank_min (blank_min)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press_mode();
      btn_mode = 1'b1; step();
      btn_mode = 1'b0; step();
   endtask

   task automatic press_inc();
      btn_inc = 1'b1; step();
      btn_inc = 1'b0; step();
   endtask

   task automatic tick();
      tick_1hz = 1'b1; step();
      tick_1hz = 1'b0; step();
   endtask

   task automatic scan();
      tick_scan = 1'b1; step();
      tick_scan = 1'b0; step();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_hr"}, hr_bcd, 8'h00);
      chk({tag, "_min"}, min_bcd, 8'h00);
      chk({tag, "_sec"}, sec_bcd, 8'h00);
      chk({tag, "_mode"}, {6'd0, mode}, 8'd0);
      chk({tag, "_blank_hr"}, {7'd0, blank_hr}, 8'd0);
      chk({tag, "_blank_min"}, {7'd0, blank_min}, 8'd0);
   endtask

   initial begin
      #2 rst = 1'b1;
      #2 chk_zero("reset");
      step(); step();
      rst = 1'b0;
      step();

      // seconds advance one cycle after the tick
      tick_1hz = 1'b1; step(); chk("tick_latency", sec_bcd, 8'h01);
      tick_1hz = 1'b0; step();
      tick(); tick();
      chk("run_sec3", sec_bcd, 8'h03);
      press_inc();
      chk("run_inc_ignored_hr", hr_bcd, 8'h00);
      chk("run_inc_ignored_min", min_bcd, 8'h00);

      // set flow
      press_mode();
      chk("mode_set_hr", {6'd0, mode}, 8'd1);
      tick();
      chk("sec_frozen", sec_bcd, 8'h03);
      for (int i = 0; i < 5; i++) press_inc();
      chk("hr_05", hr_bcd, 8'h05);
      press_mode();
      chk("mode_set_min", {6'd0, mode}, 8'd2);
      for (int i = 0; i < 60; i++) press_inc();
      chk("min_wrap_00", min_bcd, 8'h00);
      chk("hr_kept_05", hr_bcd, 8'h05);
      press_mode();
      chk("mode_run", {6'd0, mode}, 8'd0);
      chk("sec_cleared", sec_bcd, 8'h00);

      // preload 23:59:58 and roll over
      press_mode();
      for (int i = 0; i < 18; i++) press_inc();
      chk("hr_23", hr_bcd, 8'h23);
      press_mode();
      for (int i = 0; i < 59; i++) press_inc();
      chk("min_59", min_bcd, 8'h59);
      press_mode();
      for (int i = 0; i < 58; i++) tick();
      chk("sec_58", sec_bcd, 8'h58);
      tick();
      chk("t235959_hr", hr_bcd, 8'h23);
      chk("t235959_min", min_bcd, 8'h59);
      chk("t235959_sec", sec_bcd, 8'h59);
      tick();
      chk("rollover_hr", hr_bcd, 8'h00);
      chk("rollover_min", min_bcd, 8'h00);
      chk("rollover_sec", sec_bcd, 8'h00);

      // tick and mode edge together in RUN
      btn_mode = 1'b1; tick_1hz = 1'b1; step();
      chk("coinc_mode", {6'd0, mode}, 8'd1);
      chk("coinc_sec", sec_bcd, 8'h01);
      chk("coinc_blank_hr", {7'd0, blank_hr}, 8'd0);
      btn_mode = 1'b0; tick_1hz = 1'b0; step();

      // blink in SET_HR
      tick();
      chk("blink1_hr", {7'd0, blank_hr}, 8'd1);
      chk("blink1_min", {7'd0, blank_min}, 8'd0);
      tick();
      chk("blink2_hr", {7'd0, blank_hr}, 8'd0);
      tick();
      chk("blink3_hr", {7'd0, blank_hr}, 8'd1);
      chk("blink3_min", {7'd0, blank_min}, 8'd0);
      btn_inc = 1'b1; step();
      chk("inc_unblank_hr", {7'd0, blank_hr}, 8'd0);
      chk("inc_hr_01", hr_bcd, 8'h01);
      btn_inc = 1'b0; step();
      chk("set_sec_frozen", sec_bcd, 8'h01);

      // mode edge beats inc edge
      btn_mode = 1'b1; btn_inc = 1'b1; step();
      chk("prio_mode", {6'd0, mode}, 8'd2);
      chk("prio_hr", hr_bcd, 8'h01);
      chk("prio_min", min_bcd, 8'h00);
      btn_mode = 1'b0; btn_inc = 1'b0; step();
      tick();
      chk("blink_min", {7'd0, blank_min}, 8'd1);
      chk("blink_min_hr", {7'd0, blank_hr}, 8'd0);

      // auto-repeat: edge +1, hold +1 at 4th scan, repeats at 6th, 8th, 10th
      btn_inc = 1'b1; step();
      chk("hold_edge_min", min_bcd, 8'h01);
      chk("hold_edge_unblank", {7'd0, blank_min}, 8'd0);
      for (int i = 1; i <= 10; i++) begin
         scan();
         if (i == 3) chk("hold_pre_min", min_bcd, 8'h01);
         if (i == 4) chk("hold_first_min", min_bcd, 8'h02);
      end
      chk("repeat_min_05", min_bcd, 8'h05);
      btn_inc = 1'b0; step();
      scan(); scan();
      chk("release_min_05", min_bcd, 8'h05);

      // reach 12:34 in SET_MIN, hold, then reset mid-hold
      press_mode();
      chk("back_run_sec", sec_bcd, 8'h00);
      press_mode();
      for (int i = 0; i < 11; i++) press_inc();
      press_mode();
      for (int i = 0; i < 28; i++) press_inc();
      btn_inc = 1'b1; step();
      scan(); scan();
      chk("pre_rst_hr", hr_bcd, 8'h12);
      chk("pre_rst_min", min_bcd, 8'h34);
      btn_mode = 1'b1; rst = 1'b1;
      #1 chk_zero("async_rst");
      step();
      chk_zero("rst_held");
      rst = 1'b0;
      step(); step();
      chk("held_mode_after_rst", {6'd0, mode}, 8'd0);
      btn_mode = 1'b0; step();
      btn_mode = 1'b1; step();
      chk("fresh_mode_edge", {6'd0, mode}, 8'd1);
      btn_mode = 1'b0; step(); step();
      chk("held_inc_no_action", hr_bcd, 8'h00);
      btn_inc = 1'b0; step();
      press_inc();
      chk("fresh_inc_edge", hr_bcd, 8'h01);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
